// File: rtl/noc_output_arbiter_if.sv
// Output-port arbitration bundle: five requesters in, one owner out.
// master = requester/router side, slave = arbiter.
interface noc_output_arbiter_if #(parameter int SRC_W = 4);
  logic [4:0]         req;
  logic [5*SRC_W-1:0] req_src;
  logic [4:0]         flit_valid;
  logic [4:0]         tail;
  logic               out_ready;
  logic [4:0]         grant;
  logic [SRC_W-1:0]   owner_src;
  logic [2:0]         owner_gate;
  logic               busy;
  logic               xfer;

  modport master (output req, req_src, flit_valid, tail, out_ready,
                  input  grant, owner_src, owner_gate, busy, xfer);
  modport slave  (input  req, req_src, flit_valid, tail, out_ready,
                  output grant, owner_src, owner_gate, busy, xfer);
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin wormhole arbiter for one router output gate. The grant is held
// from head to tail, or until the owner stalls STALL_MAX cycles in a row.
module noc_output_arbiter #(
  parameter int SRC_W     = 4,
  parameter int STALL_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  noc_output_arbiter_if.slave  bus
);
  localparam int N_IN = 5;
  localparam int CW   = $clog2(STALL_MAX + 1);
  localparam logic [SRC_W-1:0] NO_SRC  = '1;
  localparam logic [2:0]       NO_GATE = 3'd7;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                rr_ptr, rr_nxt;
  logic [CW-1:0]             stall_cnt, stall_nxt;
  logic [N_IN-1:0]           grant_q, grant_nxt;
  logic [SRC_W-1:0]          src_q, src_nxt;
  logic [2:0]                gate_q, gate_nxt;

  logic [N_IN-1:0][SRC_W-1:0] src_arr;
  logic [N_IN-1:0]           eff_req;
  logic [7:0]                eff_ext, fv_ext, tail_ext;
  logic [2:0]                win_gate, idx_k;
  logic [SRC_W-1:0]          win_src;
  logic                      found, xfer, stall_hit, rel;

  assign src_arr = bus.req_src;

  // An all-ones source ID marks an empty slot and can never win.
  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    assign eff_req[g] = bus.req[g] & (src_arr[g] != NO_SRC);
  end

  // Pad to 8 so gate 7 (idle) indexes a harmless zero.
  assign eff_ext  = {3'b0, eff_req};
  assign fv_ext   = {3'b0, bus.flit_valid};
  assign tail_ext = {3'b0, bus.tail};

  always_comb begin
    win_gate = '0;
    idx_k    = '0;
    found    = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      idx_k = 3'((int'(rr_ptr) + k) % N_IN);
      if (!found && eff_ext[idx_k]) begin
        win_gate = idx_k;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    win_src = NO_SRC;
    for (int i = 0; i < N_IN; i++)
      if (win_gate == 3'(i)) win_src = src_arr[i];
  end

  assign xfer      = (state == LOCK) & fv_ext[gate_q] & bus.out_ready;
  assign stall_hit = (stall_cnt == CW'(STALL_MAX - 1));
  assign rel       = (state == LOCK) & (xfer ? tail_ext[gate_q] : stall_hit);

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    stall_nxt = stall_cnt;
    grant_nxt = grant_q;
    src_nxt   = src_q;
    gate_nxt  = gate_q;
    case (state)
      IDLE: begin
        if (enable && found) begin
          state_nxt = LOCK;
          grant_nxt = N_IN'(1) << win_gate;
          src_nxt   = win_src;
          gate_nxt  = win_gate;
          stall_nxt = '0;
        end
      end
      LOCK: begin
        if (xfer)                 stall_nxt = '0;
        else if (stall_cnt != '1) stall_nxt = stall_cnt + 1'b1;
        // A completed packet moves the pointer even if enable drops the same cycle.
        if (rel) rr_nxt = gate_q;
        if (rel || !enable) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          src_nxt   = NO_SRC;
          gate_nxt  = NO_GATE;
          stall_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 3'd4;
      stall_cnt <= '0;
      grant_q   <= '0;
      src_q     <= NO_SRC;
      gate_q    <= NO_GATE;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      stall_cnt <= stall_nxt;
      grant_q   <= grant_nxt;
      src_q     <= src_nxt;
      gate_q    <= gate_nxt;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner_src  = src_q;
  assign bus.owner_gate = gate_q;
  assign bus.busy       = (state == LOCK);
  assign bus.xfer       = xfer;
endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port packet arbiter for the 3x3 NoC router; one instance per output gate.
- Shares one output link among five input requesters (N, E, S, W, IP) using round-robin.
- Holds the grant from head flit to tail flit (wormhole lock).
- Publishes the owning source ID and gate so the router's source-compare logic can check per-flit handshakes against it.

Parameters:
- SRC_W, 4, width of source ID; all-ones (4'hf) means "no source".
- STALL_MAX, 15, consecutive stalled cycles in LOCK before a forced release; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arbiter enable; low forces idle.
- req  in  5  per-input request; bit0=N, bit1=E, bit2=S, bit3=W, bit4=IP (matches gate codes 0..4).
- req_src  in  5*SRC_W  packed source IDs; slice i = bits [i*SRC_W +: SRC_W].
- flit_valid  in  5  per-input flit present.
- tail  in  5  per-input marker: current flit is the tail flit.
- out_ready  in  1  downstream link can accept a flit this cycle.
- grant  out  5  one-hot grant; all zero when idle.
- owner_src  out  SRC_W  source ID of the current owner; 4'hf when idle.
- owner_gate  out  3  gate index of the current owner; 3'd7 when idle.
- busy  out  1  high in LOCK.
- xfer  out  1  combinational: flit transferred this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: grant=0, owner_src=4'hf, owner_gate=3'd7, busy=0.
  - Internal: state=IDLE, rr_ptr=4 (so input 0 (N) has first priority), stall_cnt=0.
- Effective request: eff_req[i] = req[i] & (req_src slice i != 4'hf). An ID of 4'hf never wins.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - If enable and any eff_req, pick the winner by round-robin: first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo 5.
  - Next cycle: state=LOCK, grant=1<<winner, owner_src=req_src[winner], owner_gate=winner, busy=1, stall_cnt=0.
  - Latency from request to grant: 1 cycle.
- LOCK:
  - xfer = busy & flit_valid[owner_gate] & out_ready. xfer is a pure function of current registered state and inputs.
  - xfer with tail[owner_gate]=1 -> next cycle state=IDLE, grant=0, owner_src=4'hf, owner_gate=3'd7, busy=0, rr_ptr=owner_gate.
  - xfer with tail=0 -> stay in LOCK, stall_cnt=0.
  - No xfer -> stall_cnt+1. When stall_cnt==STALL_MAX-1 and there is still no xfer, release exactly as for a tail (rr_ptr=owner_gate). stall_cnt saturates and never wraps.
  - Owner's req dropping mid-packet is ignored; the lock holds until tail or stall release.
  - req, req_src, flit_valid and tail of non-owners are ignored in LOCK.
  - owner_src is captured at grant and does not follow later changes of req_src.
- Back-to-back packets: after a release there is always exactly one IDLE cycle before the next grant. A continuously requesting input cannot win twice in a row while another input has an eff_req.
- enable low (synchronous, checked each posedge): next state=IDLE with all outputs at reset values; rr_ptr is preserved. Mid-packet disable aborts the lock.
- Simultaneous tail xfer and enable low: enable-low result applies (identical outputs); rr_ptr=owner_gate.
- stall_cnt width is ceil(log2(STALL_MAX+1)).

Test Plan:
- Reset, then req=5'b00001, src0=4'h3, flit_valid[0]=1, out_ready=1, tail on 3rd flit -> grant=00001 one cycle after req, owner_src=3, owner_gate=0, xfer high 3 cycles, grant=0 and owner_src=4'hf the cycle after the tail.
- req=5'b11111 held with every packet 1 flit -> grant order N, E, S, W, IP, N, with one idle cycle between grants.
- req=5'b00110 with src1=4'hf, src2=4'h7 -> grant=00100, owner_src=7; input 1 is never granted.
- Owner holds flit_valid=0 with STALL_MAX=15 -> release after exactly 15 LOCK cycles; next winner is the next input after the stalled one.
- Mid-packet (2 of 4 flits sent): enable=0 -> grant=0, owner_gate=7 next cycle. Re-enable -> arbitration resumes from the preserved rr_ptr.
- Assert rst_n=0 asynchronously mid-LOCK (between clock edges) -> outputs reach reset values immediately, without a clock edge; after release, N has priority.
